// File: rtl/tpu_package.sv
// Shared TPU constants and the systolic-array controller state encoding.
package tpu_package;
    localparam int ARRAY_DIM    = 32;
    localparam int RES_LATENCY  = ARRAY_DIM + 1;
    localparam int DRAIN_CYCLES = 2 * ARRAY_DIM;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } sac_state_e;
endpackage

// File: rtl/systolic_array_controller_if.sv
// Job, buffer-read and array-control signals of the systolic-array controller.
interface systolic_array_controller_if #(
    parameter int MAX_ACT_LOG2 = 8,
    parameter int WADDR_W      = $clog2(tpu_package::ARRAY_DIM)
);
    logic                    start_i;
    logic                    reuse_weights_i;
    logic [MAX_ACT_LOG2-1:0] num_act_i;
    logic                    stall_i;
    logic                    weight_rd_en_o;
    logic [WADDR_W-1:0]      weight_rd_addr_o;
    logic                    act_rd_en_o;
    logic [MAX_ACT_LOG2-1:0] act_rd_addr_o;
    logic                    load_weights_o;
    logic                    compute_o;
    logic                    stall_o;
    logic                    res_valid_o;
    logic [MAX_ACT_LOG2-1:0] res_addr_o;
    logic                    busy_o;
    logic                    done_o;

    modport master (
        input  start_i, reuse_weights_i, num_act_i, stall_i,
        output weight_rd_en_o, weight_rd_addr_o, act_rd_en_o, act_rd_addr_o,
               load_weights_o, compute_o, stall_o, res_valid_o, res_addr_o,
               busy_o, done_o
    );

    modport slave (
        output start_i, reuse_weights_i, num_act_i, stall_i,
        input  weight_rd_en_o, weight_rd_addr_o, act_rd_en_o, act_rd_addr_o,
               load_weights_o, compute_o, stall_o, res_valid_o, res_addr_o,
               busy_o, done_o
    );
endinterface

// File: rtl/sac_counter.sv
// Loadable down-counter that saturates at zero; load has priority over enable.
module sac_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);
    assign zero = (cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (en && !zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/systolic_array_controller.sv
// Sequences weight load, activation issue and pipeline drain for a square
// systolic array, and tracks which result row is on the array output.
module systolic_array_controller #(
    parameter int ARRAY_DIM    = tpu_package::ARRAY_DIM,
    parameter int MAX_ACT_LOG2 = 8
) (
    input logic clk_i,
    input logic rst_ni,
    systolic_array_controller_if.master bus
);
    import tpu_package::*;

    localparam int WADDR_W   = $clog2(ARRAY_DIM);
    localparam int PIPE_LAT  = ARRAY_DIM + 1;
    localparam int DRAIN_LEN = 2 * ARRAY_DIM;
    localparam int DRN_W     = $clog2(DRAIN_LEN);
    localparam int STAGES    = PIPE_LAT - 1;

    sac_state_e state_q, state_d;
    logic adv;

    logic                    ld_wt, en_wt, wt_zero;
    logic [WADDR_W-1:0]      wt_cnt;
    logic                    ld_iss, en_iss, iss_zero;
    logic [MAX_ACT_LOG2-1:0] iss_cnt, iss_load;
    logic                    ld_drn, en_drn, drn_zero;
    logic [DRN_W-1:0]        drn_cnt;

    logic [MAX_ACT_LOG2-1:0] num_act_q, act_addr_q, res_cnt_q;
    logic                    ldw_q, act_en_q, comp_q, done_q, busy_q;
    logic [STAGES:0]         vld_pipe;

    // Every counter, the state and the output flops advance only on unstalled cycles.
    assign adv      = !bus.stall_i;
    assign iss_load = (state_q == IDLE) ? bus.num_act_i : num_act_q;

    always_comb begin
        state_d = state_q;
        ld_wt   = 1'b0;
        en_wt   = 1'b0;
        ld_iss  = 1'b0;
        en_iss  = 1'b0;
        ld_drn  = 1'b0;
        en_drn  = 1'b0;
        case (state_q)
            IDLE: if (bus.start_i) begin
                if (bus.reuse_weights_i) begin
                    state_d = COMPUTE;
                    ld_iss  = 1'b1;
                end else begin
                    state_d = LOAD_W;
                    ld_wt   = 1'b1;
                end
            end
            LOAD_W: if (wt_zero) begin
                state_d = COMPUTE;
                ld_iss  = 1'b1;
            end else en_wt = 1'b1;
            COMPUTE: if (iss_zero) begin
                state_d = DRAIN;
                ld_drn  = 1'b1;
            end else en_iss = 1'b1;
            DRAIN: if (drn_zero) state_d = DONE;
                   else          en_drn  = 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!adv) begin
            state_d = state_q;
            ld_wt   = 1'b0;
            en_wt   = 1'b0;
            ld_iss  = 1'b0;
            en_iss  = 1'b0;
            ld_drn  = 1'b0;
            en_drn  = 1'b0;
        end
    end

    sac_counter #(.W(WADDR_W)) u_wt_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .load(ld_wt), .load_val(WADDR_W'(ARRAY_DIM - 1)),
        .en(en_wt), .cnt(wt_cnt), .zero(wt_zero)
    );

    sac_counter #(.W(MAX_ACT_LOG2)) u_iss_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .load(ld_iss), .load_val(iss_load),
        .en(en_iss), .cnt(iss_cnt), .zero(iss_zero)
    );

    sac_counter #(.W(DRN_W)) u_drn_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .load(ld_drn), .load_val(DRN_W'(DRAIN_LEN - 1)),
        .en(en_drn), .cnt(drn_cnt), .zero(drn_zero)
    );

    // Output flops are loaded from the next state so each strobe lines up with its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            num_act_q  <= '0;
            act_addr_q <= '0;
            res_cnt_q  <= '0;
            ldw_q      <= 1'b0;
            act_en_q   <= 1'b0;
            comp_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            vld_pipe   <= '0;
        end else if (adv) begin
            state_q  <= state_d;
            ldw_q    <= (state_d == LOAD_W);
            act_en_q <= (state_d == COMPUTE);
            comp_q   <= (state_d == COMPUTE) || (state_d == DRAIN);
            done_q   <= (state_d == DONE);
            busy_q   <= (state_d != IDLE);
            vld_pipe <= {vld_pipe[STAGES-1:0], act_en_q};
            if (state_q == IDLE && bus.start_i) begin
                num_act_q <= bus.num_act_i;
                res_cnt_q <= '0;
            end else if (vld_pipe[STAGES] && res_cnt_q != '1) begin
                res_cnt_q <= res_cnt_q + 1'b1;
            end
            if (ld_iss)      act_addr_q <= '0;
            else if (en_iss) act_addr_q <= act_addr_q + 1'b1;
        end
    end

    assign bus.weight_rd_en_o   = ldw_q & adv;
    assign bus.weight_rd_addr_o = wt_cnt;
    assign bus.act_rd_en_o      = act_en_q & adv;
    assign bus.act_rd_addr_o    = act_addr_q;
    assign bus.load_weights_o   = ldw_q;
    assign bus.compute_o        = comp_q;
    assign bus.stall_o          = bus.stall_i;
    assign bus.res_valid_o      = vld_pipe[STAGES] & adv;
    assign bus.res_addr_o       = res_cnt_q;
    assign bus.busy_o           = busy_q;
    assign bus.done_o           = done_q;

    a_issue_track: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == COMPUTE) |-> (act_addr_q + iss_cnt == num_act_q));
    // The last result leaves the pipe PIPE_LAT cycles into the drain window.
    a_drained: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == DRAIN && drn_cnt < DRN_W'(DRAIN_LEN - PIPE_LAT)) |-> (vld_pipe == '0));
    a_mutex: assert property (@(posedge clk_i) disable iff (!rst_ni) !(ldw_q && comp_q));
endmodule

// File: tb/tb_systolic_array_controller.sv
// Directed checks of job sequencing, stall freeze, ignored restarts and reset.
module tb_systolic_array_controller;
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    systolic_array_controller_if #(.MAX_ACT_LOG2(8), .WADDR_W(5)) bus_if ();

    systolic_array_controller #(.ARRAY_DIM(32), .MAX_ACT_LOG2(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_if)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {3'b0, bus_if.weight_rd_en_o, bus_if.weight_rd_addr_o, bus_if.act_rd_en_o,
                bus_if.act_rd_addr_o, bus_if.load_weights_o, bus_if.compute_o, bus_if.stall_o,
                bus_if.res_valid_o, bus_if.res_addr_o, bus_if.busy_o, bus_if.done_o};
    endfunction

    // Cycle 1 is the first cycle after the edge that samples start_i.
    task automatic run_job(input string tag, input logic reuse, input logic [7:0] n,
                           input int stall_addr, input int poke_cyc, input int exp_done);
        int w_cnt = 0, w_first = -1, w_prev = -1, w_bad = 0;
        int a_cnt = 0, a_first = -1, a_prev = -1, a_bad = 0, a_cyc = -1;
        int r_cnt = 0, r_prev = -1, r_bad = 0, r_cyc = -1;
        int drain = 0, done_cyc = -1, done_cnt = 0, both = 0, busy_bad = 0;
        int stall_left = 0, stall_seen = 0, stall_bad = 0;
        bit stalled = 1'b0;
        bus_if.reuse_weights_i = reuse;
        bus_if.num_act_i       = n;
        bus_if.start_i         = 1'b1;
        step();
        bus_if.start_i = 1'b0;
        for (int cyc = 1; cyc < 1000; cyc++) begin
            if (stall_addr >= 0 && !stalled && bus_if.load_weights_o &&
                int'(bus_if.weight_rd_addr_o) == stall_addr) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            bus_if.stall_i = (stall_left > 0);
            bus_if.start_i = (cyc == poke_cyc);
            #1;
            if (bus_if.stall_i) begin
                stall_seen++;
                if (bus_if.weight_rd_en_o || bus_if.act_rd_en_o || bus_if.res_valid_o ||
                    !bus_if.stall_o || int'(bus_if.weight_rd_addr_o) != stall_addr) stall_bad++;
            end else if (bus_if.stall_o) stall_bad++;
            if (bus_if.weight_rd_en_o) begin
                if (w_cnt == 0) w_first = int'(bus_if.weight_rd_addr_o);
                else if (int'(bus_if.weight_rd_addr_o) != w_prev - 1) w_bad++;
                w_prev = int'(bus_if.weight_rd_addr_o);
                w_cnt++;
            end
            if (bus_if.act_rd_en_o) begin
                if (a_cnt == 0) begin
                    a_first = int'(bus_if.act_rd_addr_o);
                    a_cyc   = cyc;
                end else if (int'(bus_if.act_rd_addr_o) != a_prev + 1) a_bad++;
                a_prev = int'(bus_if.act_rd_addr_o);
                a_cnt++;
            end
            if (bus_if.res_valid_o) begin
                if (r_cnt == 0) begin
                    r_cyc = cyc;
                    if (bus_if.res_addr_o != 0) r_bad++;
                end else if (int'(bus_if.res_addr_o) != r_prev + 1) r_bad++;
                r_prev = int'(bus_if.res_addr_o);
                r_cnt++;
            end
            if (bus_if.load_weights_o && bus_if.compute_o) both++;
            if (bus_if.compute_o && !bus_if.act_rd_en_o && !bus_if.stall_i) drain++;
            if (bus_if.done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if ((done_cyc < 0 || cyc == done_cyc) ? !bus_if.busy_o : bus_if.busy_o) busy_bad++;
            if (stall_left > 0) stall_left--;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            step();
        end
        bus_if.stall_i = 1'b0;
        bus_if.start_i = 1'b0;
        chk({tag, ".w_cnt"}, w_cnt, reuse ? 0 : 32);
        if (!reuse) begin
            chk({tag, ".w_first"}, w_first, 31);
            chk({tag, ".w_last"}, w_prev, 0);
        end
        chk({tag, ".w_order"}, w_bad, 0);
        chk({tag, ".a_cnt"}, a_cnt, int'(n) + 1);
        chk({tag, ".a_first"}, a_first, 0);
        chk({tag, ".a_last"}, a_prev, int'(n));
        chk({tag, ".a_order"}, a_bad, 0);
        chk({tag, ".r_cnt"}, r_cnt, int'(n) + 1);
        chk({tag, ".r_latency"}, r_cyc - a_cyc, 33);
        chk({tag, ".r_last"}, r_prev, int'(n));
        chk({tag, ".r_order"}, r_bad, 0);
        chk({tag, ".drain"}, drain, 64);
        chk({tag, ".done_cyc"}, done_cyc, exp_done);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".ld_and_comp"}, both, 0);
        chk({tag, ".busy"}, busy_bad, 0);
        chk({tag, ".stall"}, stall_bad, 0);
        if (stall_addr >= 0) chk({tag, ".stall_len"}, stall_seen, 5);
    endtask

    initial begin
        rst_ni                 = 1'b1;
        bus_if.start_i         = 1'b0;
        bus_if.reuse_weights_i = 1'b0;
        bus_if.num_act_i       = '0;
        bus_if.stall_i         = 1'b0;
        #2 rst_ni = 1'b0;
        #1 chk("reset.outs", outs(), 0);
        repeat (2) @(posedge clk_i);
        #4 rst_ni = 1'b1;
        step();
        chk("idle.outs", outs(), 0);

        run_job("load4", 1'b0, 8'd3, -1, 0, 101);
        run_job("reuse1", 1'b1, 8'd0, -1, 0, 66);
        run_job("stall", 1'b0, 8'd3, 20, 0, 106);
        run_job("restart", 1'b0, 8'd3, -1, 34, 101);
        run_job("max", 1'b1, 8'd255, -1, 0, 321);

        // Reset in the middle of the drain window of a fresh job.
        bus_if.reuse_weights_i = 1'b0;
        bus_if.num_act_i       = 8'd3;
        bus_if.start_i         = 1'b1;
        step();
        bus_if.start_i = 1'b0;
        repeat (59) step();
        chk("middrain.compute", bus_if.compute_o, 1);
        chk("middrain.act_addr", bus_if.act_rd_addr_o, 3);
        rst_ni = 1'b0;
        #1 chk("middrain.reset_outs", outs(), 0);
        #2 rst_ni = 1'b1;
        step();
        chk("middrain.idle", outs(), 0);
        run_job("after_rst", 1'b0, 8'd3, -1, 0, 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
